// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: holds the PC, fetches one word per instruction over a
// req/ready handshake, and computes the next PC when the controller retires the instruction.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | request outstanding at PC; waiting for IMemReady
// S_EXEC  | instruction held and valid; waiting for Retire
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Inst,
  output logic [5:0]  OpCode,
  output logic [5:0]  Func,
  output logic        InstValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        Retire,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] BranchImm,
  input  logic [31:0] RegTarget,
  output logic        AddrErr,
  output logic [31:0] RetireCount
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_capture;
  logic        w_retire;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_addr_err;
  logic [31:0] r_retire_cnt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // IMemReq is gated by rstN so the request drops the instant reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    IMemReq     = 1'b0;
    InstValid   = 1'b0;
    case (r_state)
      S_FETCH: begin
        IMemReq = rstN;
        if (IMemReady) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        InstValid = 1'b1;
        if (Retire) begin
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{BranchImm[15]}}, BranchImm, 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (PCSrc)
      2'b00: w_next_pc = w_pc_plus4;
      2'b01: w_next_pc = w_pc_plus4 + w_br_off;
      2'b10: w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
      2'b11: w_next_pc = {RegTarget[31:2], 2'b00};
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_addr_err   <= 1'b0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (w_capture) r_inst <= IMemData;
      if (w_retire) begin
        r_pc         <= w_next_pc;
        r_retire_cnt <= r_retire_cnt + 32'd1;
        if (PCSrc == 2'b11 && RegTarget[1:0] != 2'b00) r_addr_err <= 1'b1;
      end
    end
  end

  assign IMemAddr    = r_pc;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign Inst        = r_inst;
  assign OpCode      = r_inst[31:26];
  assign Func        = r_inst[5:0];
  assign AddrErr     = r_addr_err;
  assign RetireCount = r_retire_cnt;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the fetch/retire rules.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rstN;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Inst;
  logic [5:0]  OpCode;
  logic [5:0]  Func;
  logic        InstValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Retire;
  logic [1:0]  PCSrc;
  logic [15:0] BranchImm;
  logic [31:0] RegTarget;
  logic        AddrErr;
  logic [31:0] RetireCount;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  bit          m_have;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_err;
  logic [31:0] m_cnt;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rstN(rstN),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .Inst(Inst), .OpCode(OpCode), .Func(Func), .InstValid(InstValid),
    .PC(PC), .PCPlus4(PCPlus4),
    .Retire(Retire), .PCSrc(PCSrc), .BranchImm(BranchImm), .RegTarget(RegTarget),
    .AddrErr(AddrErr), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_pc = RST_PC; m_inst = '0; m_err = 0; m_cnt = '0;
  endtask

  task automatic check_all();
    chk("req",    IMemReq,     32'(!m_have && rstN));
    chk("addr",   IMemAddr,    m_pc);
    chk("pc",     PC,          m_pc);
    chk("pc4",    PCPlus4,     m_pc + 32'd4);
    chk("inst",   Inst,        m_inst);
    chk("opcode", OpCode,      32'(m_inst >> 26));
    chk("func",   Func,        32'(m_inst % 64));
    chk("valid",  InstValid,   32'(m_have));
    chk("adrerr", AddrErr,     32'(m_err));
    chk("rcount", RetireCount, m_cnt);
  endtask

  // one clock: model consumes the inputs presently driven, then outputs are compared at negedge
  task automatic step();
    logic [31:0] p4;
    int off;
    if (!m_have) begin
      if (IMemReady) begin m_inst = IMemData; m_have = 1; end
    end else if (Retire) begin
      p4  = m_pc + 32'd4;
      off = $signed(BranchImm);
      m_cnt = m_cnt + 1;
      m_have = 0;
      case (PCSrc)
        2'd0: m_pc = p4;
        2'd1: m_pc = p4 + 32'(off * 4);
        2'd2: m_pc = (p4 & 32'hF000_0000) + (m_inst & 32'h03FF_FFFF) * 4;
        default: begin
          m_pc = RegTarget - (RegTarget % 4);
          if (RegTarget % 4 != 0) m_err = 1;
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    IMemReady = 0;
    IMemData  = $urandom;
    for (int i = 0; i < waits; i++) step();
    IMemReady = 1; IMemData = data;
    step();
    IMemReady = 0;
  endtask

  task automatic retire(input logic [1:0] src, input logic [15:0] imm, input logic [31:0] tgt);
    Retire = 1; PCSrc = src; BranchImm = imm; RegTarget = tgt;
    step();
    Retire = 0;
  endtask

  // asynchronous reset pulse starting 2 time units after a negedge, spanning a posedge
  task automatic reset_pulse(input string tag);
    #2 rstN = 0;
    #1;
    chk({tag, "_req"},   IMemReq,     32'd0);
    chk({tag, "_valid"}, InstValid,   32'd0);
    chk({tag, "_err"},   AddrErr,     32'd0);
    chk({tag, "_cnt"},   RetireCount, 32'd0);
    chk({tag, "_pc"},    PC,          RST_PC);
    model_reset();
    @(negedge clk);
    rstN = 1;
    #1 check_all();
  endtask

  int cnt_before;

  initial begin
    rstN = 0; IMemReady = 0; IMemData = '0; Retire = 0; PCSrc = 0; BranchImm = 0; RegTarget = 0;
    model_reset();
    #1;
    chk("rst_req", IMemReq, 32'd0);
    chk("rst_inst", Inst, 32'd0);
    @(negedge clk); @(negedge clk);
    rstN = 1;
    #1 check_all();
    chk("first_addr", IMemAddr, 32'h40);

    // zero-wait fetches, sequential retires
    IMemReady = 1;
    IMemData = 32'h1111_0000; step();
    retire(2'd0, 16'd0, 32'd0);
    chk("seq1", IMemAddr, 32'h44);
    IMemReady = 1; step();
    retire(2'd0, 16'd0, 32'd0);
    chk("seq2", IMemAddr, 32'h48);
    chk("seq_cnt", RetireCount, 32'd2);

    // wait states
    fetch(32'h0400_0005, 3);
    chk("ws_valid", InstValid, 32'd1);
    chk("ws_op", OpCode, 32'd1);
    chk("ws_func", Func, 32'd5);

    // branches from 0x100
    retire(2'd3, 16'd0, 32'h100);
    fetch($urandom, 0);
    retire(2'd1, 16'hFFFE, 32'd0);
    chk("br_neg", PC, 32'hFC);
    fetch($urandom, 1);
    retire(2'd3, 16'd0, 32'h100);
    fetch($urandom, 0);
    retire(2'd1, 16'h0003, 32'd0);
    chk("br_pos", PC, 32'h110);

    // jump and jump-register
    fetch($urandom, 0);
    retire(2'd3, 16'd0, 32'h1000_0000);
    fetch(32'h0800_0040, 2);
    retire(2'd2, 16'd0, 32'd0);
    chk("jmp", PC, 32'h1000_0100);
    chk("jmp_err", AddrErr, 32'd0);
    fetch($urandom, 0);
    retire(2'd3, 16'd0, 32'h0000_2003);
    chk("jr", PC, 32'h2000);
    chk("jr_err", AddrErr, 32'd1);

    // Retire held for four cycles counts once
    fetch($urandom, 0);
    cnt_before = RetireCount;
    Retire = 1; PCSrc = 0;
    for (int i = 0; i < 4; i++) step();
    Retire = 0;
    chk("multi_ret", RetireCount, 32'(cnt_before + 1));
    chk("err_sticky", AddrErr, 32'd1);

    // PC wrap
    fetch($urandom, 0);
    retire(2'd3, 16'd0, 32'hFFFF_FFFC);
    fetch($urandom, 0);
    retire(2'd0, 16'd0, 32'd0);
    chk("wrap", PC, 32'd0);

    // resets mid-FETCH and mid-EXEC
    IMemReady = 0;
    step();
    reset_pulse("rstF");
    chk("rstF_restart", IMemAddr, RST_PC);
    fetch($urandom, 1);
    reset_pulse("rstE");
    chk("rstE_restart", IMemAddr, RST_PC);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      IMemReady = ($urandom_range(0, 2) != 0);
      IMemData  = $urandom;
      Retire    = ($urandom_range(0, 1) != 0);
      PCSrc     = 2'($urandom_range(0, 3));
      BranchImm = 16'($urandom);
      RegTarget = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 199) == 0) reset_pulse("rstR");
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
